// File: rtl/vid_capture_if.sv
// Framebuffer write port between the video capture block and the SDRAM arbiter.
// The head word is held on wr_adr/wr_data while wr_req=1 until wr_ack pops it.
interface vid_capture_if;
  localparam int unsigned AW = 18;
  localparam int unsigned DW = 32;

  logic          wr_req;
  logic [AW-1:0] wr_adr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;

  modport master (output wr_req, wr_adr, wr_data, input wr_ack);
  modport slave  (input wr_req, wr_adr, wr_data, output wr_ack);
endinterface

// File: rtl/vid_capture.sv
// Monochrome 1024x768 video capture: packs 32 pixels per word LSB-first and
// writes them into the framebuffer, line 0 at the top address, lines descending.
module vid_capture #(
  parameter logic [17:0] ORG    = 18'h37FC0,
  parameter int unsigned HWORDS = 32,
  parameter int unsigned VLINES = 768
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  input  logic            hsync,
  input  logic            vsync,
  input  logic            de,
  input  logic            pix,
  input  logic            inv,
  input  logic            enable,
  vid_capture_if.master   wr,
  output logic            frame_done,
  output logic            ovf
);
  localparam int unsigned AW = 18;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 10;
  localparam int unsigned WW = 6;
  localparam int unsigned BW = 5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_CAPT  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          vs_q, de_q, hs_q, en_q, line_act_q;
  logic [LW-1:0] line_q, line_d;
  logic [WW-1:0] word_q, word_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DW-1:0] shift_q, shift_d;
  logic          pend_v_q;
  logic [AW-1:0] pend_adr_q;
  logic [DW-1:0] pend_dat_q;
  logic          h_v_q, h_v_d, t_v_q, t_v_d;
  logic [AW-1:0] h_adr_q, h_adr_d, t_adr_q, t_adr_d;
  logic [DW-1:0] h_dat_q, h_dat_d, t_dat_q, t_dat_d;
  logic          ovf_q, ovf_d, frame_done_q;

  logic          vs_rise, vs_fall, de_fall, hs_fall;
  logic          cap_entry, frame_end, in_capt, active;
  logic          pix_take, word_full, flush, line_adv, drop, pop;
  logic          push_v;
  logic [AW-1:0] push_adr;
  logic [DW-1:0] word_v;

  // Edges between successive ce samples
  assign vs_rise = ce &  vsync & ~vs_q;
  assign vs_fall = ce & ~vsync &  vs_q;
  assign de_fall = ce & ~de    &  de_q;
  assign hs_fall = ce & ~hsync &  hs_q;

  always_comb begin
    state_d   = state_q;
    cap_entry = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      S_IDLE:  if (vs_rise) state_d = S_ARMED;
      S_ARMED: if (vs_fall && en_q) begin
                 state_d   = S_CAPT;
                 cap_entry = 1'b1;
               end
      S_CAPT:  if (vs_rise) begin
                 state_d   = S_ARMED;
                 frame_end = 1'b1;
               end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_capt   = (state_q == S_CAPT);
  assign active    = in_capt && (32'(line_q) < VLINES) && (32'(word_q) < HWORDS);
  assign pix_take  = active & ce & de;
  assign word_full = pix_take && (bit_q == 5'd31);
  // A line only advances if de was seen since the last hsync
  assign line_adv  = in_capt & de_fall & line_act_q;
  assign flush     = in_capt && (line_adv || vs_rise) && (bit_q != 5'd0) && !word_full;
  assign push_v    = word_full | flush;
  assign push_adr  = ORG + {3'b000, ~line_q, word_q[4:0]};

  always_comb begin
    word_v = shift_q;
    if (pix_take) word_v[bit_q] = pix ^ inv;
    shift_d = word_v;
    line_d  = line_q;
    word_d  = word_q;
    bit_d   = bit_q;
    if (cap_entry) begin
      line_d  = '0;
      word_d  = '0;
      bit_d   = '0;
      shift_d = '0;
    end else if (in_capt) begin
      if (line_adv) begin
        line_d  = (line_q == 10'd1023) ? line_q : line_q + 10'd1;
        word_d  = '0;
        bit_d   = '0;
        shift_d = '0;
      end else if (vs_rise || word_full) begin
        word_d  = vs_rise ? 6'd0 : word_q + 6'd1;
        bit_d   = '0;
        shift_d = '0;
      end else if (pix_take) begin
        bit_d = bit_q + 5'd1;
      end
    end
  end

  // Two-entry FIFO as head/tail registers; head drives the write port
  assign pop = h_v_q & wr.wr_ack;
  always_comb begin
    h_v_d = h_v_q; h_adr_d = h_adr_q; h_dat_d = h_dat_q;
    t_v_d = t_v_q; t_adr_d = t_adr_q; t_dat_d = t_dat_q;
    drop  = 1'b0;
    if (pop) begin
      if (t_v_q) begin
        h_adr_d = t_adr_q; h_dat_d = t_dat_q;
        t_v_d   = pend_v_q; t_adr_d = pend_adr_q; t_dat_d = pend_dat_q;
      end else begin
        h_v_d   = pend_v_q; h_adr_d = pend_adr_q; h_dat_d = pend_dat_q;
      end
    end else if (pend_v_q) begin
      if (!h_v_q) begin
        h_v_d = 1'b1; h_adr_d = pend_adr_q; h_dat_d = pend_dat_q;
      end else if (!t_v_q) begin
        t_v_d = 1'b1; t_adr_d = pend_adr_q; t_dat_d = pend_dat_q;
      end else begin
        drop = 1'b1;
      end
    end
    ovf_d = cap_entry ? 1'b0 : (ovf_q | drop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      hs_q         <= 1'b1;
      en_q         <= 1'b0;
      line_act_q   <= 1'b0;
      line_q       <= '0;
      word_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      pend_v_q     <= 1'b0;
      pend_adr_q   <= '0;
      pend_dat_q   <= '0;
      h_v_q        <= 1'b0;
      h_adr_q      <= '0;
      h_dat_q      <= '0;
      t_v_q        <= 1'b0;
      t_adr_q      <= '0;
      t_dat_q      <= '0;
      ovf_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ce) begin
        vs_q <= vsync;
        de_q <= de;
        hs_q <= hsync;
      end
      if (vs_rise) en_q <= enable;
      if (ce && de)   line_act_q <= 1'b1;
      else if (hs_fall) line_act_q <= 1'b0;
      line_q       <= line_d;
      word_q       <= word_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      pend_v_q     <= push_v;
      if (push_v) begin
        pend_adr_q <= push_adr;
        pend_dat_q <= word_v;
      end
      h_v_q        <= h_v_d;
      h_adr_q      <= h_adr_d;
      h_dat_q      <= h_dat_d;
      t_v_q        <= t_v_d;
      t_adr_q      <= t_adr_d;
      t_dat_q      <= t_dat_d;
      ovf_q        <= ovf_d;
      frame_done_q <= frame_end;
    end
  end

  assign wr.wr_req   = h_v_q;
  assign wr.wr_adr   = h_adr_q;
  assign wr.wr_data  = h_dat_q;
  assign frame_done  = frame_done_q;
  assign ovf         = ovf_q;
endmodule

// File: tb/tb_vid_capture.sv
// Directed bench for vid_capture: table of captured lines plus hand-written
// sequences for full frame, backpressure/overflow, enable gating and reset.
module tb_vid_capture;
  logic clk = 1'b0;
  logic rst_n, ce, hsync, vsync, de, pix, inv, enable;
  logic frame_done, ovf;

  vid_capture_if bus();

  vid_capture dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .hsync(hsync), .vsync(vsync), .de(de),
    .pix(pix), .inv(inv), .enable(enable), .wr(bus.master),
    .frame_done(frame_done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [17:0] adr; logic [31:0] data; } wr_t;
  typedef struct {
    int          npix;
    bit          single;
    logic        pv;
    logic        iv;
    int          nwr;
    logic [17:0] adr0;
    logic [31:0] d0;
    logic [31:0] dmid;
    logic [17:0] adrl;
    logic [31:0] dl;
  } vec_t;

  wr_t  wq[$];
  int   req_cnt = 0, fd_cnt = 0, stab_viol = 0;
  logic hold_q = 1'b0;
  logic [17:0] prev_adr = '0;
  logic [31:0] prev_dat = '0;
  int   checks = 0, errors = 0;

  // Write-port monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (bus.wr_req && bus.wr_ack) wq.push_back(wr_t'{bus.wr_adr, bus.wr_data});
    if (bus.wr_req) req_cnt++;
    if (frame_done) fd_cnt++;
    if (hold_q && bus.wr_req && (bus.wr_adr != prev_adr || bus.wr_data != prev_dat))
      stab_viol++;
    hold_q   = bus.wr_req && !bus.wr_ack;
    prev_adr = bus.wr_adr;
    prev_dat = bus.wr_data;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic vs_rise(input logic en);
    vsync = 1'b1; enable = en; step(2);
  endtask

  task automatic vs_fall();
    vsync = 1'b0; step(2);
  endtask

  task automatic run_line(input int npix, input bit single, input logic pv, input logic iv);
    inv = iv;
    for (int i = 0; i < npix; i++) begin
      de = 1'b1; pix = single ? (i == 0) : pv; step();
    end
    de = 1'b0; pix = 1'b0; step(2);
    hsync = 1'b0; step(2);
    hsync = 1'b1; step(2);
  endtask

  vec_t vt[8];
  int   w0, n, bad, fd0, req0;
  wr_t  e;
  logic [31:0] xd;

  initial begin
    vt[0] = '{1024, 1'b1, 1'b0, 1'b0, 32, 18'h3FFA0, 32'h00000001, 32'h0,        18'h3FFBF, 32'h0};
    vt[1] = '{40,   1'b0, 1'b1, 1'b0, 2,  18'h3FF80, 32'hFFFFFFFF, 32'h0,        18'h3FF81, 32'h000000FF};
    vt[2] = '{32,   1'b0, 1'b0, 1'b1, 1,  18'h3FF60, 32'hFFFFFFFF, 32'h0,        18'h3FF60, 32'hFFFFFFFF};
    vt[3] = '{5,    1'b0, 1'b1, 1'b1, 1,  18'h3FF40, 32'h0,        32'h0,        18'h3FF40, 32'h0};
    vt[4] = '{64,   1'b0, 1'b1, 1'b0, 2,  18'h3FF20, 32'hFFFFFFFF, 32'h0,        18'h3FF21, 32'hFFFFFFFF};
    vt[5] = '{0,    1'b0, 1'b0, 1'b0, 0,  18'h0,     32'h0,        32'h0,        18'h0,     32'h0};
    vt[6] = '{33,   1'b0, 1'b1, 1'b0, 2,  18'h3FF00, 32'hFFFFFFFF, 32'h0,        18'h3FF01, 32'h00000001};
    vt[7] = '{1030, 1'b0, 1'b1, 1'b0, 32, 18'h3FEE0, 32'hFFFFFFFF, 32'hFFFFFFFF, 18'h3FEFF, 32'hFFFFFFFF};

    rst_n = 1'b0; ce = 1'b1; hsync = 1'b1; vsync = 1'b0; de = 1'b0;
    pix = 1'b0; inv = 1'b0; enable = 1'b0; bus.wr_ack = 1'b1;
    step(2);
    chk("rst_wr_req", bus.wr_req, 0);
    chk("rst_wr_adr", bus.wr_adr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1; step(2);

    // Frame 1: table of lines
    vs_rise(1'b1); vs_fall();
    for (int v = 0; v < 8; v++) begin
      w0 = wq.size();
      run_line(vt[v].npix, vt[v].single, vt[v].pv, vt[v].iv);
      n = wq.size() - w0;
      chk($sformatf("v%0d_nwr", v), n, vt[v].nwr);
      if (n > 0 && n == vt[v].nwr) begin
        chk($sformatf("v%0d_adr0", v), wq[w0].adr, vt[v].adr0);
        chk($sformatf("v%0d_d0", v), wq[w0].data, vt[v].d0);
        chk($sformatf("v%0d_adrl", v), wq[w0+n-1].adr, vt[v].adrl);
        chk($sformatf("v%0d_dl", v), wq[w0+n-1].data, vt[v].dl);
        bad = 0;
        for (int i = 0; i < n; i++) begin
          e  = wq[w0+i];
          xd = (i == 0) ? vt[v].d0 : (i == n-1) ? vt[v].dl : vt[v].dmid;
          if (e.adr != vt[v].adr0 + 18'(i) || e.data != xd) bad++;
        end
        chk($sformatf("v%0d_seq", v), bad, 0);
      end
    end
    fd0 = fd_cnt;
    vs_rise(1'b1);
    chk("f1_frame_done", fd_cnt - fd0, 1);
    vs_fall();

    // Frame 2: full frame, 767 short lines then a full last line, then one ignored line
    w0 = wq.size(); fd0 = fd_cnt;
    for (int ln = 0; ln < 767; ln++) run_line(32, 1'b0, 1'b0, 1'b1);
    run_line(1024, 1'b0, 1'b0, 1'b1);
    run_line(32, 1'b0, 1'b0, 1'b1);
    n = wq.size() - w0;
    chk("ff_nwr", n, 799);
    bad = 0;
    for (int i = 0; i < n; i++) if (wq[w0+i].data != 32'hFFFFFFFF) bad++;
    chk("ff_data", bad, 0);
    if (n > 0) chk("ff_last_adr", wq[w0+n-1].adr, 18'h39FDF);
    chk("ff_fd_before_end", fd_cnt - fd0, 0);
    vs_rise(1'b1);
    chk("ff_frame_done", fd_cnt - fd0, 1);
    chk("ff_ovf", ovf, 0);
    vs_fall();

    // Frame 3: backpressure, third word dropped
    bus.wr_ack = 1'b0; w0 = wq.size();
    run_line(96, 1'b0, 1'b1, 1'b0);
    chk("bp_wr_req", bus.wr_req, 1);
    chk("bp_head_adr", bus.wr_adr, 18'h3FFA0);
    chk("bp_head_data", bus.wr_data, 32'hFFFFFFFF);
    chk("bp_ovf", ovf, 1);
    chk("bp_stable", stab_viol, 0);
    bus.wr_ack = 1'b1; step(6);
    n = wq.size() - w0;
    chk("bp_nwr", n, 2);
    if (n == 2) begin
      chk("bp_w0_adr", wq[w0].adr, 18'h3FFA0);
      chk("bp_w1_adr", wq[w0+1].adr, 18'h3FFA1);
      chk("bp_w1_data", wq[w0+1].data, 32'hFFFFFFFF);
    end
    vs_rise(1'b1);
    chk("bp_ovf_armed", ovf, 1);
    vs_fall();
    chk("bp_ovf_clr", ovf, 0);

    // Empty frame ends with enable=0 at the rise; next frame is skipped
    fd0 = fd_cnt;
    vs_rise(1'b0);
    chk("en_empty_frame_done", fd_cnt - fd0, 1);
    vs_fall();
    req0 = req_cnt; w0 = wq.size();
    run_line(64, 1'b0, 1'b1, 1'b0);
    chk("en0_req", req_cnt - req0, 0);
    fd0 = fd_cnt;
    vs_rise(1'b1);
    chk("en0_frame_done", fd_cnt - fd0, 0);
    vs_fall();
    w0 = wq.size();
    run_line(64, 1'b0, 1'b1, 1'b0);
    chk("en1_nwr", wq.size() - w0, 2);

    // Reset mid-line with two queued words and a partial word
    bus.wr_ack = 1'b0;
    for (int i = 0; i < 74; i++) begin de = 1'b1; pix = 1'b1; step(); end
    chk("rs_pre_req", bus.wr_req, 1);
    rst_n = 1'b0; #1;
    chk("rs_req_async", bus.wr_req, 0);
    de = 1'b0; step(2);
    rst_n = 1'b1; bus.wr_ack = 1'b1; step();
    req0 = req_cnt; w0 = wq.size();
    run_line(64, 1'b0, 1'b1, 1'b0);
    chk("rs_no_wr", req_cnt - req0, 0);
    vs_rise(1'b1); vs_fall();
    w0 = wq.size();
    run_line(32, 1'b0, 1'b1, 1'b0);
    n = wq.size() - w0;
    chk("rs_resume_nwr", n, 1);
    if (n == 1) chk("rs_resume_adr", wq[w0].adr, 18'h3FFA0);
    fd0 = fd_cnt;
    vs_rise(1'b1);
    chk("rs_frame_done", fd_cnt - fd0, 1);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
